count_seq_monitor: RTL and testbench

- Sits directly downstream of the 3-bit synchronous up-counter and consumes its count output.
- Checks that successive sampled values step by +1 modulo 2^WIDTH.
- Locks onto a valid sequence, then flags sequence breaks and counts wrap-arounds.
- Used as an in-system checker and wrap-event source for downstream logic.

---
 rtl/count_mon_pkg.sv | 19 +
 rtl/gray2bin.sv | 14 +
 rtl/count_seq_monitor.sv | 115 +++++++++++
 tb/tb_count_seq_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count sequence monitor.
// Optional Gray-coded input is enabled by defining COUNT_SEQ_MONITOR_GRAY_EN.
package count_mon_pkg;

  typedef enum logic [0:0] {
    MON_UNLOCKED = 1'b0,
    MON_LOCKED   = 1'b1
  } mon_state_t;

  localparam int unsigned MON_WIDTH = 3;
  localparam int unsigned MON_MAX   = (1 << MON_WIDTH) - 1;

  // Statistics counters stop at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    if (val >= max_val) return max_val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; used only when COUNT_SEQ_MONITOR_GRAY_EN is defined.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that sampled counter values step by +1 mod 2^WIDTH, locks on, reports breaks and wraps.
// Define COUNT_SEQ_MONITOR_GRAY_EN to accept a Gray-coded count_in.
//
//   state        | meaning
//   MON_UNLOCKED | acquiring: counting consecutive good steps, no error/wrap reporting
//   MON_LOCKED   | tracking: a mismatch is an error, a max->0 step is a wrap
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              valid_in,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [31:0]      STAT_MAX = 32'((64'd1 << STAT_W) - 64'd1);

  mon_state_t       state;
  logic [WIDTH-1:0] cnt_bin;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic             prev_valid;
  logic [3:0]       good_run;
  logic             checked;
  logic             step_ok;
  logic             err_evt;
  logic             wrap_evt;

`ifdef COUNT_SEQ_MONITOR_GRAY_EN
  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (count_in),
    .bin  (cnt_bin)
  );
`else
  assign cnt_bin = count_in;
`endif

  assign expected = prev + WIDTH'(1);
  assign step_ok  = (cnt_bin == expected);
  assign checked  = valid_in && prev_valid;
  assign err_evt  = checked && (state == MON_LOCKED) && !step_ok;
  assign wrap_evt = checked && (state == MON_LOCKED) && step_ok && (prev == CNT_MAX);
  assign locked   = (state == MON_LOCKED);

  // The error sample itself becomes the new anchor, so reacquisition starts at the next sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= MON_UNLOCKED;
      prev       <= '0;
      prev_valid <= 1'b0;
      good_run   <= '0;
    end else if (valid_in) begin
      prev       <= cnt_bin;
      prev_valid <= 1'b1;
      if (prev_valid) begin
        unique case (state)
          MON_UNLOCKED: begin
            if (!step_ok) begin
              good_run <= '0;
            end else if (good_run == LOCK_LAST) begin
              state    <= MON_LOCKED;
              good_run <= '0;
            end else begin
              good_run <= good_run + 4'd1;
            end
          end
          MON_LOCKED: begin
            if (!step_ok) begin
              state    <= MON_UNLOCKED;
              good_run <= '0;
            end
          end
          default: state <= MON_UNLOCKED;
        endcase
      end
    end
  end

  // An event in the same cycle as clear wins: the counter restarts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      wrap_pulse <= wrap_evt;
      err_pulse  <= err_evt;

      if (err_evt)    err_sticky <= 1'b1;
      else if (clear) err_sticky <= 1'b0;

      if (err_evt)    err_count <= clear ? STAT_W'(1) : STAT_W'(sat_inc(32'(err_count), STAT_MAX));
      else if (clear) err_count <= '0;

      if (wrap_evt)   wrap_count <= clear ? STAT_W'(1) : STAT_W'(sat_inc(32'(wrap_count), STAT_MAX));
      else if (clear) wrap_count <= '0;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: directed test-plan sequences plus randomized traffic.
// Drives Gray-coded counts when COUNT_SEQ_MONITOR_GRAY_EN is defined.
module tb_count_seq_monitor;

  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 2;
  localparam int STAT_W   = 2;
  localparam int MODV     = 1 << WIDTH;
  localparam int SAT      = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  count_in = '0;
  logic              valid_in = 1'b0;
  logic              clear = 1'b0;
  logic              locked;
  logic              wrap_pulse;
  logic              err_pulse;
  logic              err_sticky;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;

  count_seq_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .valid_in   (valid_in),
    .clear      (clear),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit wp;
    bit ep;
    bit es;
    int ec;
    int wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state
  bit m_have;
  int m_prev;
  bit m_lock;
  int m_run;
  bit m_es;
  int m_ec;
  int m_wc;
  int last;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [WIDTH-1:0] enc(input int c);
    logic [WIDTH-1:0] b;
    b = WIDTH'(c);
`ifdef COUNT_SEQ_MONITOR_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_lock = 0; m_run = 0;
    m_es = 0; m_ec = 0; m_wc = 0;
  endtask

  task automatic drive(input bit v, input int c, input bit clr);
    exp_t e;
    bit err, wrap;
    @(negedge clk);
    valid_in = v;
    count_in = enc(c);
    clear    = clr;
    err = 0;
    wrap = 0;
    if (v) begin
      if (m_have) begin
        if (c == (m_prev + 1) % MODV) begin
          if (m_lock) begin
            wrap = (m_prev == MODV - 1);
          end else begin
            m_run++;
            if (m_run == LOCK_CNT) begin
              m_lock = 1;
              m_run = 0;
            end
          end
        end else begin
          if (m_lock) begin
            err = 1;
            m_lock = 0;
          end
          m_run = 0;
        end
      end
      m_have = 1;
      m_prev = c;
      last = c;
    end
    if (clr) begin
      m_ec = 0; m_wc = 0; m_es = 0;
    end
    if (err) begin
      m_ec = (m_ec < SAT) ? m_ec + 1 : SAT;
      m_es = 1;
    end
    if (wrap) m_wc = (m_wc < SAT) ? m_wc + 1 : SAT;
    e.lk = m_lock; e.wp = wrap; e.ep = err; e.es = m_es; e.ec = m_ec; e.wc = m_wc;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_err_sticky"}, int'(err_sticky), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_wrap_count"}, int'(wrap_count), 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    clear = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic seq(input int a, input int b, input int c);
    drive(1, a, 0);
    drive(1, b, 0);
    drive(1, c, 0);
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("wrap_pulse", int'(wrap_pulse), int'(e.wp));
        chk("err_pulse", int'(err_pulse), int'(e.ep));
        chk("err_sticky", int'(err_sticky), int'(e.es));
        chk("err_count", int'(err_count), e.ec);
        chk("wrap_count", int'(wrap_count), e.wc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    last = 0;
    #2;
    check_all_zero("reset");
    #8;
    reset = 1'b1;

    // lock-on, wrap, break and relock
    for (int i = 0; i < 4; i++) drive(1, i, 0);
    for (int i = 4; i < 8; i++) drive(1, i, 0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    seq(2, 3, 5);
    drive(1, 6, 0);
    drive(1, 7, 0);
    drive(1, 0, 0);

    // stall and valid gap
    drive(1, 4, 0);
    seq(5, 6, 7);
    drive(1, 0, 0);
    drive(1, 4, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    drive(1, 5, 0);
    drive(1, 5, 0);
    drive(1, 5, 0);

    // saturation: five locked breaks
    for (int k = 0; k < 5; k++) begin
      seq(0, 1, 2);
      drive(1, 5, 0);
    end
    drive(0, 0, 1);
    seq(0, 1, 2);
    drive(1, 5, 1);
    drive(0, 0, 0);

    // async reset while locked, first sample afterwards is not checked
    seq(0, 1, 2);
    drive(1, 3, 0);
    mid_reset();
    drive(1, 6, 0);
    seq(7, 0, 1);
    drive(1, 2, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      int c;
      bit v;
      bit clr;
      r   = int'($urandom_range(0, 15));
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if (r == 0)      c = int'($urandom_range(0, MODV - 1));
      else if (r == 1) c = last;
      else             c = (last + 1) % MODV;
      drive(v, c, clr);
      if (n == 300) mid_reset();
    end

    @(negedge clk);
    valid_in = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
